// File: rtl/bc6502_pkg.sv
// Shared definitions for the bc6502 status register: P bit positions,
// flag-op encodings and branch-condition encodings.
package bc6502_pkg;

  localparam int unsigned P_C = 0;
  localparam int unsigned P_Z = 1;
  localparam int unsigned P_I = 2;
  localparam int unsigned P_D = 3;
  localparam int unsigned P_B = 4;
  localparam int unsigned P_U = 5;
  localparam int unsigned P_V = 6;
  localparam int unsigned P_N = 7;

  typedef enum logic [2:0] {
    FOP_NONE = 3'd0,
    FOP_CLC  = 3'd1,
    FOP_SEC  = 3'd2,
    FOP_CLI  = 3'd3,
    FOP_SEI  = 3'd4,
    FOP_CLV  = 3'd5,
    FOP_CLD  = 3'd6,
    FOP_SED  = 3'd7
  } fop_e;

  typedef enum logic [2:0] {
    BR_BPL = 3'd0,
    BR_BMI = 3'd1,
    BR_BVC = 3'd2,
    BR_BVS = 3'd3,
    BR_BCC = 3'd4,
    BR_BCS = 3'd5,
    BR_BNE = 3'd6,
    BR_BEQ = 3'd7
  } br_cond_e;

endpackage

// File: rtl/so_edge_sync.sv
// Synchroniser plus falling-edge detector for an asynchronous active-low pin.
// All flops reset to the idle (high) level so reset release never looks like an edge.
module so_edge_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din_n,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              dly;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '1;
      dly  <= 1'b1;
    end else begin
      sync <= {sync[STAGES-2:0], din_n};
      dly  <= sync[STAGES-1];
    end
  end

  assign fall = dly & ~sync[STAGES-1];

endmodule

// File: rtl/bc6502_status_reg.sv
// bc6502 processor status (P) register with branch evaluation and SO pin handling.
// Define BC6502_CLR_D_ON_INT_EN for 65C02 behaviour (interrupt entry clears D).
module bc6502_status_reg
  import bc6502_pkg::*;
#(
  parameter int unsigned SO_SYNC_STAGES = 2,
  parameter logic        RESET_I        = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rdy,
  input  logic       ld_nz,
  input  logic       ld_c,
  input  logic       ld_v,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       bit_op,
  input  logic       ld_p,
  input  logic [7:0] db_i,
  input  logic [2:0] fop,
  input  logic       int_entry,
  input  logic       brk_push,
  input  logic [2:0] br_cond,
  input  logic       so_n,
  output logic [7:0] p_o,
  output logic       n_o,
  output logic       v_o,
  output logic       z_o,
  output logic       c_o,
  output logic       d_o,
  output logic       i_o,
  output logic       br_take,
  output logic       so_event
);

  logic n, v, z, c, d, i;
  logic n_nxt, v_nxt, z_nxt, c_nxt, d_nxt, i_nxt;
  logic so_fall;
  fop_e fop_op;

  assign fop_op = fop_e'(fop);

  so_edge_sync #(.STAGES(SO_SYNC_STAGES)) u_so_sync (
    .clk  (clk),
    .rst  (reset),
    .din_n(so_n),
    .fall (so_fall)
  );

  always_comb begin
    n_nxt = n;
    v_nxt = v;
    z_nxt = z;
    c_nxt = c;
    d_nxt = d;
    i_nxt = i;
    if (rdy) begin
      if (ld_p)        n_nxt = db_i[P_N];
      else if (bit_op) n_nxt = db_i[P_N];
      else if (ld_nz)  n_nxt = alu_n;

      if (ld_p)                  v_nxt = db_i[P_V];
      else if (bit_op)           v_nxt = db_i[P_V];
      else if (ld_v)             v_nxt = alu_v;
      else if (fop_op == FOP_CLV) v_nxt = 1'b0;

      if (ld_p)        z_nxt = db_i[P_Z];
      else if (bit_op) z_nxt = alu_z;
      else if (ld_nz)  z_nxt = alu_z;

      if (ld_p)                   c_nxt = db_i[P_C];
      else if (ld_c)              c_nxt = alu_c;
      else if (fop_op == FOP_CLC) c_nxt = 1'b0;
      else if (fop_op == FOP_SEC) c_nxt = 1'b1;

      if (ld_p)                   i_nxt = db_i[P_I];
      else if (int_entry)         i_nxt = 1'b1;
      else if (fop_op == FOP_CLI) i_nxt = 1'b0;
      else if (fop_op == FOP_SEI) i_nxt = 1'b1;

      if (ld_p)                   d_nxt = db_i[P_D];
`ifdef BC6502_CLR_D_ON_INT_EN
      else if (int_entry)         d_nxt = 1'b0;
`endif
      else if (fop_op == FOP_CLD) d_nxt = 1'b0;
      else if (fop_op == FOP_SED) d_nxt = 1'b1;
    end
    // SO ignores rdy and beats every other V source in the same cycle.
    if (so_fall) v_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n        <= 1'b0;
      v        <= 1'b0;
      z        <= 1'b0;
      c        <= 1'b0;
      d        <= 1'b0;
      i        <= RESET_I;
      so_event <= 1'b0;
    end else begin
      n        <= n_nxt;
      v        <= v_nxt;
      z        <= z_nxt;
      c        <= c_nxt;
      d        <= d_nxt;
      i        <= i_nxt;
      so_event <= so_fall;
    end
  end

  always_comb begin
    p_o      = '0;
    p_o[P_N] = n;
    p_o[P_V] = v;
    p_o[P_U] = 1'b1;
    p_o[P_B] = brk_push;
    p_o[P_D] = d;
    p_o[P_I] = i;
    p_o[P_Z] = z;
    p_o[P_C] = c;
  end

  assign n_o = n;
  assign v_o = v;
  assign z_o = z;
  assign c_o = c;
  assign d_o = d;
  assign i_o = i;

  always_comb begin
    br_take = 1'b0;
    case (br_cond_e'(br_cond))
      BR_BPL:  br_take = ~n;
      BR_BMI:  br_take = n;
      BR_BVC:  br_take = ~v;
      BR_BVS:  br_take = v;
      BR_BCC:  br_take = ~c;
      BR_BCS:  br_take = c;
      BR_BNE:  br_take = ~z;
      BR_BEQ:  br_take = z;
      default: br_take = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_bc6502_status_reg.sv
// Directed self-checking bench for bc6502_status_reg.
module tb_bc6502_status_reg;

  logic       clk, reset, rdy, ld_nz, ld_c, ld_v;
  logic       alu_n, alu_z, alu_c, alu_v, bit_op, ld_p;
  logic [7:0] db_i;
  logic [2:0] fop;
  logic       int_entry, brk_push;
  logic [2:0] br_cond;
  logic       so_n;
  logic [7:0] p_o;
  logic       n_o, v_o, z_o, c_o, d_o, i_o, br_take, so_event;

  int total = 0;
  int bad   = 0;

  bc6502_status_reg #(.SO_SYNC_STAGES(2), .RESET_I(1'b1)) dut (
    .clk(clk), .reset(reset), .rdy(rdy), .ld_nz(ld_nz), .ld_c(ld_c), .ld_v(ld_v),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .bit_op(bit_op), .ld_p(ld_p), .db_i(db_i), .fop(fop),
    .int_entry(int_entry), .brk_push(brk_push), .br_cond(br_cond), .so_n(so_n),
    .p_o(p_o), .n_o(n_o), .v_o(v_o), .z_o(z_o), .c_o(c_o), .d_o(d_o), .i_o(i_o),
    .br_take(br_take), .so_event(so_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    rdy = 1'b1; ld_nz = 1'b0; ld_c = 1'b0; ld_v = 1'b0;
    alu_n = 1'b0; alu_z = 1'b0; alu_c = 1'b0; alu_v = 1'b0;
    bit_op = 1'b0; ld_p = 1'b0; db_i = 8'h00; fop = 3'd0;
    int_entry = 1'b0; brk_push = 1'b0; br_cond = 3'd0;
  endtask

  task automatic load_p(input logic [7:0] val);
    idle_inputs();
    ld_p = 1'b1; db_i = val;
    step();
    ld_p = 1'b0; db_i = 8'h00;
  endtask

  task automatic test_reset;
    total++; if (p_o !== 8'h24) begin bad++; $display("FAIL reset_p got=%h exp=%h", p_o, 8'h24); end
    total++; if (so_event !== 1'b0) begin bad++; $display("FAIL reset_so got=%b exp=0", so_event); end
    load_p(8'hFF);
    total++; if (p_o !== 8'hEF) begin bad++; $display("FAIL load_ff got=%h exp=%h", p_o, 8'hEF); end
    #3 reset = 1'b1;
    #1;
    total++; if (p_o !== 8'h24) begin bad++; $display("FAIL midreset_p got=%h exp=%h", p_o, 8'h24); end
    total++; if (so_event !== 1'b0) begin bad++; $display("FAIL midreset_so got=%b exp=0", so_event); end
    #1 reset = 1'b0;
    step();
    total++; if (p_o !== 8'h24) begin bad++; $display("FAIL after_reset got=%h exp=%h", p_o, 8'h24); end
  endtask

  task automatic test_ld_p;
    load_p(8'hC3);
    total++; if (p_o !== 8'hE3) begin bad++; $display("FAIL ld_p got=%h exp=%h", p_o, 8'hE3); end
    br_cond = 3'd3; #1;
    total++; if (br_take !== 1'b1) begin bad++; $display("FAIL br_bvs got=%b exp=1", br_take); end
    br_cond = 3'd4; #1;
    total++; if (br_take !== 1'b0) begin bad++; $display("FAIL br_bcc got=%b exp=0", br_take); end
    brk_push = 1'b1; #1;
    total++; if (p_o !== 8'hF3) begin bad++; $display("FAIL brk_push got=%h exp=%h", p_o, 8'hF3); end
    brk_push = 1'b0;
    rdy = 1'b0; ld_p = 1'b1; db_i = 8'h00; ld_nz = 1'b1; ld_c = 1'b1; fop = 3'd1;
    step();
    total++; if (p_o !== 8'hE3) begin bad++; $display("FAIL rdy_hold got=%h exp=%h", p_o, 8'hE3); end
    idle_inputs();
  endtask

  task automatic test_branch;
    logic [7:0] exp_a, exp_b;
    exp_a = 8'b0110_0110;  // P=0x81: N=1 V=0 Z=0 C=1
    exp_b = 8'b1001_1001;  // P=0x42: N=0 V=1 Z=1 C=0
    load_p(8'h81);
    for (int k = 0; k < 8; k++) begin
      br_cond = 3'(k); #1;
      total++; if (br_take !== exp_a[k]) begin bad++; $display("FAIL br_a%0d got=%b exp=%b", k, br_take, exp_a[k]); end
    end
    load_p(8'h42);
    for (int k = 0; k < 8; k++) begin
      br_cond = 3'(k); #1;
      total++; if (br_take !== exp_b[k]) begin bad++; $display("FAIL br_b%0d got=%b exp=%b", k, br_take, exp_b[k]); end
    end
    br_cond = 3'd0;
  endtask

  task automatic test_so;
    int pulses;
    int got;
    load_p(8'h24);
    rdy = 1'b0; so_n = 1'b0;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (so_event === 1'b1) pulses++;
      if (k < 2) begin
        total++; if (v_o !== 1'b0) begin bad++; $display("FAIL so_early%0d got=%b exp=0", k, v_o); end
      end
      if (k == 2) begin
        total++; if (p_o !== 8'h64) begin bad++; $display("FAIL so_set got=%h exp=%h", p_o, 8'h64); end
        total++; if (so_event !== 1'b1) begin bad++; $display("FAIL so_pulse got=%b exp=1", so_event); end
      end
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL so_single got=%0d exp=1", pulses); end
    so_n = 1'b1; rdy = 1'b1; fop = 3'd5;
    step();
    fop = 3'd0;
    step(); step(); step();
    total++; if (v_o !== 1'b0) begin bad++; $display("FAIL so_clv got=%b exp=0", v_o); end
    so_n = 1'b0; rdy = 1'b0;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (so_event === 1'b1) got++;
    end
    total++; if (got != 1) begin bad++; $display("FAIL so_second got=%0d exp=1", got); end
    total++; if (v_o !== 1'b1) begin bad++; $display("FAIL so_second_v got=%b exp=1", v_o); end
    so_n = 1'b1;
    step(); step(); step(); step();
    idle_inputs();
  endtask

  task automatic test_so_override;
    rdy = 1'b1; ld_v = 1'b1; alu_v = 1'b0; so_n = 1'b0;
    step(); step();
    total++; if (v_o !== 1'b0) begin bad++; $display("FAIL ovr_ldv_pre got=%b exp=0", v_o); end
    step();
    total++; if (v_o !== 1'b1) begin bad++; $display("FAIL ovr_ldv got=%b exp=1", v_o); end
    step();
    total++; if (v_o !== 1'b0) begin bad++; $display("FAIL ovr_ldv_post got=%b exp=0", v_o); end
    ld_v = 1'b0; fop = 3'd5; so_n = 1'b1;
    step(); step(); step(); step();
    so_n = 1'b0;
    step(); step(); step();
    total++; if (v_o !== 1'b1) begin bad++; $display("FAIL ovr_clv got=%b exp=1", v_o); end
    step();
    total++; if (v_o !== 1'b0) begin bad++; $display("FAIL ovr_clv_post got=%b exp=0", v_o); end
    so_n = 1'b1;
    step(); step(); step(); step();
    idle_inputs();
  endtask

  task automatic test_bit_op;
    load_p(8'h81);
    bit_op = 1'b1; db_i = 8'h40; alu_z = 1'b1; ld_nz = 1'b1; alu_n = 1'b1;
    step();
    total++; if ({n_o, v_o, z_o, c_o} !== 4'b0111) begin bad++; $display("FAIL bit_op got=%b exp=%b", {n_o, v_o, z_o, c_o}, 4'b0111); end
    idle_inputs();
  endtask

  task automatic test_fop;
    load_p(8'h24);
    fop = 3'd2; step();
    total++; if (c_o !== 1'b1) begin bad++; $display("FAIL sec got=%b exp=1", c_o); end
    fop = 3'd1; step();
    total++; if (c_o !== 1'b0) begin bad++; $display("FAIL clc got=%b exp=0", c_o); end
    fop = 3'd7; step();
    total++; if (d_o !== 1'b1) begin bad++; $display("FAIL sed got=%b exp=1", d_o); end
    fop = 3'd6; step();
    total++; if (d_o !== 1'b0) begin bad++; $display("FAIL cld got=%b exp=0", d_o); end
    fop = 3'd3; step();
    total++; if (i_o !== 1'b0) begin bad++; $display("FAIL cli got=%b exp=0", i_o); end
    fop = 3'd4; step();
    total++; if (i_o !== 1'b1) begin bad++; $display("FAIL sei got=%b exp=1", i_o); end
    ld_c = 1'b1; alu_c = 1'b1; fop = 3'd1; step();
    total++; if (c_o !== 1'b1) begin bad++; $display("FAIL ldc_over_clc got=%b exp=1", c_o); end
    idle_inputs();
  endtask

  task automatic test_int;
    logic exp_d;
    load_p(8'h08);
    int_entry = 1'b1; fop = 3'd3;
    step();
`ifdef BC6502_CLR_D_ON_INT_EN
    exp_d = 1'b0;
`else
    exp_d = 1'b1;
`endif
    total++; if (i_o !== 1'b1) begin bad++; $display("FAIL int_cli got=%b exp=1", i_o); end
    total++; if (d_o !== exp_d) begin bad++; $display("FAIL int_d got=%b exp=%b", d_o, exp_d); end
    load_p(8'h00);
    int_entry = 1'b1; fop = 3'd7;
    step();
    total++; if (d_o !== exp_d) begin bad++; $display("FAIL int_sed got=%b exp=%b", d_o, exp_d); end
    load_p(8'h00);
    int_entry = 1'b1; ld_p = 1'b1; db_i = 8'h08;
    step();
    total++; if ({d_o, i_o} !== 2'b10) begin bad++; $display("FAIL int_ldp got=%b exp=10", {d_o, i_o}); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    so_n  = 1'b1;
    reset = 1'b1;
    #12 reset = 1'b0;
    #1;
    test_reset();
    test_ld_p();
    test_branch();
    test_so();
    test_so_override();
    test_bit_op();
    test_fop();
    test_int();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
